// File: rtl/ddr5_sched_queue.sv
// DDR5 scheduler request queue: decodes CPU requests into DRAM coordinates, keeps them
// compacted in arrival order with per-entry ages, and picks FCFS or row-hit-first.
module ddr5_sched_queue #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 34,
   parameter int CH_BITS   = 1,
   parameter int AGE_W     = 8,
   parameter int AGE_LIMIT = 100,
   parameter int MODE      = 1,
   localparam int ROW_W    = ADDR_W - 17 - CH_BITS,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_core,
   input  logic [1:0]         in_op,
   input  logic [ADDR_W-1:0]  in_addr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_core,
   output logic [1:0]         out_op,
   output logic [ROW_W-1:0]   out_row,
   output logic [9:0]         out_col,
   output logic [1:0]         out_bank,
   output logic [2:0]         out_bg,
   output logic [CH_BITS-1:0] out_ch,
   output logic               out_hit,
   output logic [AGE_W-1:0]   out_age,
   input  logic               act_valid,
   input  logic               pre_valid,
   input  logic [CH_BITS-1:0] cmd_ch,
   input  logic [2:0]         cmd_bg,
   input  logic [1:0]         cmd_bank,
   input  logic [ROW_W-1:0]   act_row,
   input  logic               ref_all,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int TBL_W = CH_BITS + 5;
   localparam int TBL_N = 1 << TBL_W;

   logic [3:0]         core_r [DEPTH];
   logic [1:0]         op_r   [DEPTH];
   logic [ROW_W-1:0]   row_r  [DEPTH];
   logic [9:0]         col_r  [DEPTH];
   logic [1:0]         bank_r [DEPTH];
   logic [2:0]         bg_r   [DEPTH];
   logic [CH_BITS-1:0] ch_r   [DEPTH];
   logic [AGE_W-1:0]   age_r  [DEPTH];
   logic [CNT_W-1:0]   count_r;
   logic               full_r;
   logic               empty_r;
   logic [TBL_N-1:0]   open_r;
   logic [ROW_W-1:0]   orow_r [TBL_N];

   logic [DEPTH-1:0]   hit_s;
   logic [IDX_W-1:0]   sel_s;
   logic               enq_s;
   logic               deq_s;
   logic [CNT_W-1:0]   count_nxt_s;
   logic [IDX_W-1:0]   wslot_s;
   logic [TBL_W-1:0]   cmd_idx_s;

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (a == {AGE_W{1'b1}}) ? a : a + AGE_W'(1);
   endfunction

   function automatic logic [TBL_W-1:0] tbl_idx(input logic [CH_BITS-1:0] ch,
                                                input logic [2:0] bg, input logic [1:0] bank);
      return {ch, bg, bank};
   endfunction

   assign enq_s       = in_valid & ~full_r;
   assign deq_s       = ~empty_r & out_ready;
   assign count_nxt_s = count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
   assign wslot_s     = IDX_W'(count_r - CNT_W'(deq_s));
   assign cmd_idx_s   = tbl_idx(cmd_ch, cmd_bg, cmd_bank);

   assign in_ready  = ~full_r;
   assign out_valid = ~empty_r;
   assign count     = count_r;
   assign full      = full_r;
   assign empty     = empty_r;

   // Per-entry row-hit flags against the open-row table
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_r) begin
            hit_s[i] = open_r[tbl_idx(ch_r[i], bg_r[i], bank_r[i])] &&
                       (orow_r[tbl_idx(ch_r[i], bg_r[i], bank_r[i])] == row_r[i]);
         end else begin
            hit_s[i] = 1'b0;
         end
      end
   end

   // Entry selection: oldest, or lowest-index hit unless the oldest has starved
   always_comb begin
      sel_s = '0;
      if ((MODE != 0) && (age_r[0] < AGE_W'(AGE_LIMIT))) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_s = hit_s[i] ? IDX_W'(i) : sel_s;
         end
      end else begin
         sel_s = '0;
      end
   end

   // Output fields of the selected entry, forced to zero when empty
   always_comb begin
      if (!empty_r) begin
         out_core = core_r[sel_s];
         out_op   = op_r[sel_s];
         out_row  = row_r[sel_s];
         out_col  = col_r[sel_s];
         out_bank = bank_r[sel_s];
         out_bg   = bg_r[sel_s];
         out_ch   = ch_r[sel_s];
         out_hit  = hit_s[sel_s];
         out_age  = age_r[sel_s];
      end else begin
         out_core = '0;
         out_op   = '0;
         out_row  = '0;
         out_col  = '0;
         out_bank = '0;
         out_bg   = '0;
         out_ch   = '0;
         out_hit  = 1'b0;
         out_age  = '0;
      end
   end

   // Queue storage: compaction on dequeue, ageing, append at first free slot
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            core_r[i] <= '0;
            op_r[i]   <= '0;
            row_r[i]  <= '0;
            col_r[i]  <= '0;
            bank_r[i] <= '0;
            bg_r[i]   <= '0;
            ch_r[i]   <= '0;
            age_r[i]  <= '0;
         end
      end else begin
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_W'(DEPTH));
         empty_r <= (count_nxt_s == CNT_W'(0));
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (deq_s && (IDX_W'(i) >= sel_s)) begin
               core_r[i] <= core_r[i+1];
               op_r[i]   <= op_r[i+1];
               row_r[i]  <= row_r[i+1];
               col_r[i]  <= col_r[i+1];
               bank_r[i] <= bank_r[i+1];
               bg_r[i]   <= bg_r[i+1];
               ch_r[i]   <= ch_r[i+1];
               age_r[i]  <= age_inc(age_r[i+1]);
            end else begin
               age_r[i]  <= age_inc(age_r[i]);
            end
         end
         age_r[DEPTH-1] <= age_inc(age_r[DEPTH-1]);
         if (enq_s) begin
            core_r[wslot_s] <= in_core;
            op_r[wslot_s]   <= in_op;
            row_r[wslot_s]  <= in_addr[17+CH_BITS +: ROW_W];
            col_r[wslot_s]  <= {in_addr[11+CH_BITS +: 6], in_addr[5:2]};
            bank_r[wslot_s] <= in_addr[9+CH_BITS +: 2];
            bg_r[wslot_s]   <= in_addr[6+CH_BITS +: 3];
            ch_r[wslot_s]   <= in_addr[6 +: CH_BITS];
            age_r[wslot_s]  <= '0;
         end
      end
   end

   // Open-row table; ACT to a bank overrides a same-cycle PRE or refresh
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         open_r <= '0;
         for (int k = 0; k < TBL_N; k++) begin
            orow_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < TBL_N; k++) begin
            if (act_valid && (TBL_W'(k) == cmd_idx_s)) begin
               open_r[k] <= 1'b1;
               orow_r[k] <= act_row;
            end else if (ref_all || (pre_valid && (TBL_W'(k) == cmd_idx_s))) begin
               open_r[k] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr5_sched_queue.sv
// Directed self-checking bench for ddr5_sched_queue in row-hit-first mode with defaults.
module tb_ddr5_sched_queue;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_core = '0;
   logic [1:0]  in_op = '0;
   logic [33:0] in_addr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_core;
   logic [1:0]  out_op;
   logic [15:0] out_row;
   logic [9:0]  out_col;
   logic [1:0]  out_bank;
   logic [2:0]  out_bg;
   logic [0:0]  out_ch;
   logic        out_hit;
   logic [7:0]  out_age;
   logic        act_valid = 1'b0;
   logic        pre_valid = 1'b0;
   logic [0:0]  cmd_ch = '0;
   logic [2:0]  cmd_bg = '0;
   logic [1:0]  cmd_bank = '0;
   logic [15:0] act_row = '0;
   logic        ref_all = 1'b0;
   logic [4:0]  count;
   logic        full;
   logic        empty;

   int n_vec = 0;
   int n_err = 0;
   logic done;

   ddr5_sched_queue dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core), .out_op(out_op),
      .out_row(out_row), .out_col(out_col), .out_bank(out_bank), .out_bg(out_bg), .out_ch(out_ch),
      .out_hit(out_hit), .out_age(out_age),
      .act_valid(act_valid), .pre_valid(pre_valid), .cmd_ch(cmd_ch), .cmd_bg(cmd_bg),
      .cmd_bank(cmd_bank), .act_row(act_row), .ref_all(ref_all),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] mkaddr(input logic [15:0] row, input logic [2:0] bg,
                                          input logic [1:0] bank);
      return {row, 6'd0, bank, bg, 1'b0, 4'd0, 2'b00};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic enq(input logic [3:0] core, input logic [33:0] addr);
      in_valid = 1'b1;
      in_core  = core;
      in_op    = 2'd0;
      in_addr  = addr;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic deq(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   task automatic bank_cmd(input logic act, input logic pre, input logic [2:0] bg,
                           input logic [1:0] bank, input logic [15:0] row);
      act_valid = act;
      pre_valid = pre;
      cmd_bg    = bg;
      cmd_bank  = bank;
      act_row   = row;
      tick();
      act_valid = 1'b0;
      pre_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_row", out_row, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // address decode and one-cycle latency
      enq(4'd3, 34'h0_0004_0480);
      chk("dec_valid", out_valid, 1);
      chk("dec_row", out_row, 1);
      chk("dec_bg", out_bg, 1);
      chk("dec_bank", out_bank, 1);
      chk("dec_ch", out_ch, 0);
      chk("dec_col", out_col, 0);
      chk("dec_core", out_core, 3);
      chk("dec_age0", out_age, 0);
      tick();
      chk("dec_age1", out_age, 1);
      deq(1);
      chk("dec_drained", empty, 1);
      chk("dec_zero_core", out_core, 0);

      // row-hit-first selection
      enq(4'd1, mkaddr(16'd5, 3'd0, 2'd0));
      enq(4'd2, mkaddr(16'd7, 3'd0, 2'd0));
      chk("hit_pre_core", out_core, 1);
      chk("hit_pre_hit", out_hit, 0);
      bank_cmd(1'b1, 1'b0, 3'd0, 2'd0, 16'd7);
      chk("hit_sel_core", out_core, 2);
      chk("hit_sel_hit", out_hit, 1);
      deq(1);
      chk("hit_after_core", out_core, 1);
      chk("hit_after_hit", out_hit, 0);
      chk("hit_after_count", count, 1);
      deq(1);

      // starvation limit forces the oldest miss out
      enq(4'd9, mkaddr(16'd9, 3'd0, 2'd0));
      enq(4'd4, mkaddr(16'd7, 3'd0, 2'd0));
      chk("age_hit_first", out_core, 4);
      chk("age_hit_flag", out_hit, 1);
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         in_valid  = 1'b1;
         in_core   = 4'd4;
         in_addr   = mkaddr(16'd7, 3'd0, 2'd0);
         out_ready = 1'b1;
         tick();
         if (out_core == 4'd9) done = 1'b1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("age_forced", done, 1);
      chk("age_value", out_age, 100);
      chk("age_miss", out_hit, 0);
      chk("age_count", count, 2);
      deq(2);
      chk("age_drained", empty, 1);

      // ACT beats PRE on the same bank, refresh closes everything
      enq(4'd5, mkaddr(16'd7, 3'd1, 2'd2));
      chk("actpre_before", out_hit, 0);
      bank_cmd(1'b1, 1'b1, 3'd1, 2'd2, 16'd7);
      chk("actpre_open", out_hit, 1);
      ref_all = 1'b1;
      tick();
      ref_all = 1'b0;
      chk("ref_closed", out_hit, 0);
      deq(1);

      // full queue refuses enqueue even while dequeuing
      for (int i = 0; i < 16; i++) enq(4'(i), mkaddr(16'(i), 3'd0, 2'd0));
      chk("full_count", count, 16);
      chk("full_flag", full, 1);
      chk("full_in_ready", in_ready, 0);
      in_valid  = 1'b1;
      in_core   = 4'd15;
      in_addr   = mkaddr(16'd99, 3'd0, 2'd0);
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("full_deq_count", count, 15);
      chk("full_deq_flag", full, 0);
      chk("full_deq_core", out_core, 1);
      deq(10);
      chk("drain_count", count, 5);
      chk("drain_core", out_core, 11);
      bank_cmd(1'b1, 1'b0, 3'd0, 2'd0, 16'd11);
      chk("drain_hit", out_hit, 1);

      // asynchronous reset mid-operation
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_empty", empty, 1);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      enq(4'd7, mkaddr(16'd11, 3'd0, 2'd0));
      chk("arst_core", out_core, 7);
      chk("arst_banks_closed", out_hit, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
